// File: rtl/alu_4bit_pkg.sv
// Shared opcode encodings and flag bundle for the 4-bit ALU.
package alu_4bit_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_ADD = 3'b000;
   localparam opcode_t OP_SUB = 3'b001;
   localparam opcode_t OP_AND = 3'b010;
   localparam opcode_t OP_OR  = 3'b011;
   localparam opcode_t OP_XOR = 3'b100;
   localparam opcode_t OP_NOT = 3'b101;
   localparam opcode_t OP_SHL = 3'b110;
   localparam opcode_t OP_SHR = 3'b111;

   typedef struct packed {
      logic carry;
      logic zero;
      logic negative;
      logic overflow;
   } flags_t;

   localparam flags_t FLAGS_RST = '{carry: 1'b0, zero: 1'b1, negative: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_4bit_comb.sv
// Combinational 4-bit ALU datapath: result, carry/borrow and signed overflow.
// Latency: none (pure logic).
// Backpressure: none; the registering parent decides when results are captured.
module alu_4bit_comb
   import alu_4bit_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  opcode_t    sel,
   output logic [3:0] result,
   output logic       carry,
   output logic       overflow
);

   logic [4:0] sum5;
   logic [4:0] diff5;

   // Bit 4 of the zero-extended difference is the borrow (A < B unsigned).
   assign sum5  = {1'b0, A} + {1'b0, B};
   assign diff5 = {1'b0, A} - {1'b0, B};

   always_comb begin
      result   = 4'b0000;
      carry    = 1'b0;
      overflow = 1'b0;
      case (sel)
         OP_ADD: begin
            result   = sum5[3:0];
            carry    = sum5[4];
            overflow = (A[3] == B[3]) && (sum5[3] != A[3]);
         end
         OP_SUB: begin
            result   = diff5[3:0];
            carry    = diff5[4];
            overflow = (A[3] != B[3]) && (diff5[3] != A[3]);
         end
         OP_AND: result = A & B;
         OP_OR:  result = A | B;
         OP_XOR: result = A ^ B;
         OP_NOT: result = ~A;
         OP_SHL: begin
            result = {A[2:0], 1'b0};
            carry  = A[3];
         end
         OP_SHR: begin
            result = {1'b0, A[3:1]};
            carry  = A[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_4bit_core.sv
// Registered 4-bit ALU with carry/zero/negative/overflow flags.
// Latency: 1 cycle from an in_valid sample to out_valid.
// Backpressure: none; accepts one op per cycle, outputs hold while in_valid is low.
module alu_4bit_core
   import alu_4bit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [2:0] sel,
   output logic [3:0] result,
   output logic       carry,
   output logic       zero,
   output logic       negative,
   output logic       overflow,
   output logic       out_valid
);

   logic [3:0] comb_result;
   logic       comb_carry;
   logic       comb_overflow;
   logic [3:0] result_q;
   flags_t     flags_q;
   logic       out_valid_q;

   alu_4bit_comb u_comb (
      .A        (A),
      .B        (B),
      .sel      (sel),
      .result   (comb_result),
      .carry    (comb_carry),
      .overflow (comb_overflow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q    <= 4'b0000;
         flags_q     <= FLAGS_RST;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            result_q          <= comb_result;
            flags_q.carry     <= comb_carry;
            flags_q.zero      <= (comb_result == 4'b0000);
            flags_q.negative  <= comb_result[3];
            flags_q.overflow  <= comb_overflow;
         end
      end
   end

   assign result    = result_q;
   assign carry     = flags_q.carry;
   assign zero      = flags_q.zero;
   assign negative  = flags_q.negative;
   assign overflow  = flags_q.overflow;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_4bit_core.sv
// Self-checking bench for alu_4bit_core: directed vector table, hold/reset sequences, random run.
module tb_alu_4bit_core;

   typedef struct packed {
      logic [3:0] res;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } exp_t;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] sel;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic [2:0] sel = 3'd0;
   logic [3:0] result;
   logic       carry, zero, negative, overflow, out_valid;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sbq[$];
   exp_t held;
   exp_t rst_exp;

   alu_4bit_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Reference model built on integer arithmetic rather than bit slicing.
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
      exp_t m;
      int ua, ub, sa, sb, r, sr;
      ua = int'(a);
      ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      r  = 0;
      m  = '0;
      case (s)
         3'd0: begin r = ua + ub; m.c = (r > 15); sr = sa + sb; m.v = (sr > 7) || (sr < -8); end
         3'd1: begin r = ua - ub; m.c = (ua < ub); sr = sa - sb; m.v = (sr > 7) || (sr < -8); end
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: r = 15 - ua;
         3'd6: begin r = ua * 2; m.c = (ua >= 8); end
         default: begin r = ua / 2; m.c = (ua % 2) == 1; end
      endcase
      m.res = 4'(r & 15);
      m.z   = (m.res == 4'd0);
      m.n   = (r & 8) != 0;
      return m;
   endfunction

   task automatic cmp_out(input string tag, input exp_t e);
      vectors++;
      if ({result, carry, zero, negative, overflow} !== {e.res, e.c, e.z, e.n, e.v}) begin
         miscompares++;
         $display("FAIL %s: got res=%b c=%b z=%b n=%b v=%b, expected res=%b c=%b z=%b n=%b v=%b",
                  tag, result, carry, zero, negative, overflow, e.res, e.c, e.z, e.n, e.v);
      end
   endtask

   task automatic cmp_vld(input string tag, input logic exp_v);
      vectors++;
      if (out_valid !== exp_v) begin
         miscompares++;
         $display("FAIL %s out_valid: got %b, expected %b", tag, out_valid, exp_v);
      end
   endtask

   // Drive one cycle at negedge, push the expectation, then check just after the edge.
   task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic v, input exp_t e);
      @(negedge clk);
      A = a; B = b; sel = s; in_valid = v;
      if (v) sbq.push_back(e);
      @(posedge clk);
      #1;
      cmp_vld(tag, v);
      if (out_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: got out_valid=1, expected empty queue to be non-empty", tag);
         end else begin
            held = sbq.pop_front();
         end
      end
      cmp_out(tag, held);
   endtask

   vec_t tbl[13];

   initial begin
      rst_exp = '{res: 4'b0000, c: 1'b0, z: 1'b1, n: 1'b0, v: 1'b0};
      held    = rst_exp;

      //          a        b        sel     res      c     z     n     v
      tbl[0]  = '{4'b0101, 4'b0011, 3'b000, '{4'b1000, 1'b0, 1'b0, 1'b1, 1'b1}};
      tbl[1]  = '{4'b0101, 4'b0011, 3'b001, '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[2]  = '{4'b0101, 4'b0011, 3'b010, '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[3]  = '{4'b0101, 4'b0011, 3'b011, '{4'b0111, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[4]  = '{4'b0101, 4'b0011, 3'b100, '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[5]  = '{4'b1111, 4'b0001, 3'b000, '{4'b0000, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[6]  = '{4'b0011, 4'b0101, 3'b001, '{4'b1110, 1'b1, 1'b0, 1'b1, 1'b0}};
      tbl[7]  = '{4'b1000, 4'b0001, 3'b001, '{4'b0111, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[8]  = '{4'b1010, 4'b0110, 3'b101, '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[9]  = '{4'b1001, 4'b0000, 3'b110, '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[10] = '{4'b1001, 4'b1111, 3'b111, '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[11] = '{4'b0111, 4'b0001, 3'b000, '{4'b1000, 1'b0, 1'b0, 1'b1, 1'b1}};
      tbl[12] = '{4'b1100, 4'b1100, 3'b001, '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0}};

      // Reset state.
      @(posedge clk);
      #1;
      cmp_vld("reset", 1'b0);
      cmp_out("reset", rst_exp);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, back-to-back.
      for (int i = 0; i < 13; i++)
         step($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sel, 1'b1, tbl[i].e);

      // Hold: one valid op, then idle cycles with changing inputs.
      step("hold_load", 4'b0010, 4'b0011, 3'b000, 1'b1, '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++)
         step($sformatf("hold%0d", i), 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, '0);

      // Asynchronous reset between edges, no clock edge needed.
      step("pre_rst", 4'b1001, 4'b1001, 3'b011, 1'b1, '{4'b1001, 1'b0, 1'b0, 1'b1, 1'b0});
      #2;
      rst = 1'b1;
      #1;
      held = rst_exp;
      cmp_vld("async_rst", 1'b0);
      cmp_out("async_rst", rst_exp);

      // Op presented during reset is discarded.
      @(negedge clk);
      A = 4'b0111; B = 4'b0111; sel = 3'b000; in_valid = 1'b1;
      @(posedge clk);
      #1;
      cmp_vld("in_rst", 1'b0);
      cmp_out("in_rst", rst_exp);
      #1;
      rst = 1'b0;

      // First valid after release is sampled at the next edge.
      step("post_rst", 4'b0110, 4'b0001, 3'b001, 1'b1, '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0});

      // Random run against the model.
      for (int i = 0; i < 1000; i++) begin
         logic [3:0] ra, rb;
         logic [2:0] rs;
         logic       rv;
         ra = 4'($urandom);
         rb = 4'($urandom);
         rs = 3'($urandom);
         rv = 1'($urandom_range(0, 1));
         step("rand", ra, rb, rs, rv, model(ra, rb, rs));
      end

      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_4bit_core.md
# alu_4bit_core

Registered 4-bit arithmetic/logic unit implementing the `alu_4bit` function set. It takes two 4-bit operands and a 3-bit opcode, and produces a 4-bit result plus status flags one clock after the operands are accepted. It sits as a leaf datapath block beneath small sequencers and controllers that need a single-cycle-latency ALU with flags.

## Interface
- No parameters; widths fixed: data 4 bits, opcode 3 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands and opcode are valid this cycle.
- `A` input 4: operand A, unsigned or two's complement.
- `B` input 4: operand B.
- `sel` input 3: opcode.
- `result` output 4: registered result.
- `carry` output 1: carry out (ADD) or borrow (SUB/shifts as defined below).
- `zero` output 1: result == 4'b0000.
- `negative` output 1: result[3].
- `overflow` output 1: signed overflow (ADD/SUB only, else 0).
- `out_valid` output 1: outputs hold a fresh result this cycle.

## Operation
- Opcodes:
  - `000` ADD: A+B, carry = bit 4 of the 5-bit sum.
  - `001` SUB: A−B mod 16, carry = borrow (1 when A < B unsigned).
  - `010` AND: A & B.
  - `011` OR: A | B.
  - `100` XOR: A ^ B.
  - `101` NOT: ~A, B ignored.
  - `110` SHL: A<<1, carry = A[3].
  - `111` SHR logical: A>>1, carry = A[0].
- Carry is 0 for logic ops (`010`–`101`).
- Overflow:
  - ADD: A[3]==B[3] and sum[3]!=A[3].
  - SUB: A[3]!=B[3] and diff[3]!=A[3].
  - All other ops: 0.
- `zero` and `negative` are derived from the 4-bit result for every opcode.
- Inputs are sampled only when `in_valid`=1. When `in_valid`=0, `result` and all flags hold their previous values.

## Timing
- Reset (asynchronous, immediate): `result`=0, `carry`=0, `overflow`=0, `negative`=0, `zero`=1, `out_valid`=0.
- Latency: exactly 1 cycle. A/B/sel sampled at edge N with `in_valid`=1 appear on the outputs after edge N, and `out_valid`=1 for that cycle.
- `out_valid` is the registered `in_valid`. Back-to-back operations are accepted every cycle, throughput 1 per cycle.
- Reset mid-operation discards the in-flight operation. The first valid input after `rst` deasserts is sampled at the next rising edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package `alu_4bit_pkg`:
  - opcode constants `OP_ADD`..`OP_SHR`.
  - a typedef for the 3-bit opcode.
  - a typedef for the flag bundle.
- One combinational sub-module `alu_4bit_comb` (A, B, sel → result, carry, overflow). The top holds the output/flag registers and `out_valid`.

## Test plan
- A=0101, B=0011, `in_valid`=1, sel stepped 000..100 one per cycle → results 1000, 0010, 0001, 0111, 0110, each one cycle later. ADD sets overflow=1, negative=1, carry=0. SUB carry=0.
- A=1111, B=0001, ADD → result 0000, carry=1, zero=1, overflow=0. SUB with A=0011, B=0101 → 1110, carry=1, negative=1.
- A=1000, B=0001, SUB → 0111, overflow=1. NOT on A=1010 → 0101. SHL on 1001 → 0010, carry=1. SHR on 1001 → 0100, carry=1.
- Apply one valid op, then `in_valid`=0 with changing A/B/sel → outputs hold, `out_valid`=0.
- Assert `rst` asynchronously between edges while a result is held → outputs immediately take reset values (zero=1), with no clock edge required.
- Random A/B/sel, 1000 cycles, with `in_valid` toggling → every output matches the golden model delayed one cycle.
